// File: rtl/square_pow2k_pkg.sv
// Shared types for the sequential x^(2^k) block over GF(2^8) in the
// redundant (8+d)-bit representation.
package square_pow2k_pkg;

    localparam int D     = 1;
    localparam int SW    = 8 + D;
    localparam int MROWS = 7 + 2 * D;
    localparam int PRE_W = 15 + 2 * D;
    localparam int MAX_K = 7;
    localparam int KW    = $clog2(MAX_K + 1);

    typedef logic [SW-1:0]          state_t;
    typedef logic [D-1:0]           red_poly_t;
    typedef logic [MROWS-1:0][7:0]  mul_m_matrix_t;
    typedef logic [KW-1:0]          cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Clamp a requested exponent count to the largest supported one.
    function automatic cnt_t sat_k(input cnt_t k_in);
        logic [KW:0] k_ext;
        k_ext = {1'b0, k_in};
        if (k_ext > (KW + 1)'(MAX_K)) begin
            return cnt_t'(MAX_K);
        end
        return k_in;
    endfunction

endpackage

// File: rtl/square_pow2k_if.sv
// Operand, randomness and result channels of square_pow2k plus FSM debug state.
interface square_pow2k_if;
    import square_pow2k_pkg::*;

    // Every channel transfers on a clock edge where valid and ready are both 1;
    // valid never waits on ready, and payload is only meaningful while valid=1.
    logic          in_valid;
    logic          in_ready;
    state_t        in_data;
    cnt_t          k;
    mul_m_matrix_t B_ext;
    logic          rnd_valid;
    red_poly_t     rnd;
    logic          rnd_ready;
    logic          out_valid;
    logic          out_ready;
    state_t        out_data;
    logic          busy;
    fsm_t          dbg_state;

    modport slave (
        input  in_valid, in_data, k, B_ext, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, out_data, busy, dbg_state
    );

    modport master (
        output in_valid, in_data, k, B_ext, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, out_data, busy, dbg_state
    );

endinterface

// File: rtl/square_pow2k_sq.sv
// Combinational square-and-refresh step: spreads the operand bits to even
// positions and folds the overflow back through the extended reduction matrix.
module square_pow2k_sq
    import square_pow2k_pkg::*;
(
    input  state_t        a,
    input  red_poly_t     r,
    input  mul_m_matrix_t b_ext,
    output state_t        y
);

    logic [PRE_W-1:0] pre;
    logic [MROWS-1:0] fold;
    state_t           red;

    always_comb begin
        pre = '0;
        for (int i = 0; i < SW; i++) begin
            pre[2*i] = a[i];
        end

        // Fresh polynomial occupies the low rows, overflow bits the rest.
        fold = '0;
        for (int j = 0; j < D; j++) begin
            fold[j] = r[j];
        end
        for (int j = 0; j < MROWS - D; j++) begin
            fold[D+j] = pre[8+D+j];
        end

        red = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < MROWS; j++) begin
                red[i] = red[i] ^ (fold[j] & b_ext[j][i]);
            end
        end
        for (int j = 0; j < D; j++) begin
            red[8+j] = r[j];
        end

        y = pre[SW-1:0] ^ red;
    end

endmodule

// File: rtl/square_pow2k.sv
// Sequential x^(2^k): loads an operand, applies k square-and-refresh steps,
// one fresh reduction polynomial per step, then presents the result.
module square_pow2k
    import square_pow2k_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    square_pow2k_if.slave   bus
);

    fsm_t   state_q, state_d;
    state_t acc_q, acc_d;
    cnt_t   cnt_q, cnt_d;
    logic   in_ready_q, in_ready_d;
    logic   rnd_ready_q, rnd_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   busy_q, busy_d;
    state_t sq_y;

    square_pow2k_sq u_sq (
        .a     (acc_q),
        .r     (bus.rnd),
        .b_ext (bus.B_ext),
        .y     (sq_y)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = bus.in_data;
                    cnt_d   = sat_k(bus.k);
                    state_d = (cnt_d == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // rnd_ready is 1 throughout RUN; without rnd_valid everything holds.
                if (bus.rnd_valid) begin
                    acc_d = sq_y;
                    cnt_d = cnt_q - cnt_t'(1);
                    if (cnt_q == cnt_t'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        rnd_ready_d = (state_d == RUN);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            rnd_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            rnd_ready_q <= rnd_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.rnd_ready = rnd_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;

endmodule
